// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - merges MEM/ALU writebacks into the single regfile write port
// In-order FIFO drained one entry per cycle, with a youngest-first bypass lookup for decode.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             MemValid,
  input  logic [4:0]       MemReg,
  input  logic [31:0]      MemData,
  output logic             MemReady,
  input  logic             AluValid,
  input  logic [4:0]       AluReg,
  input  logic [31:0]      AluData,
  output logic             AluReady,
  output logic             Write1,
  output logic [4:0]       WriteReg1,
  output logic [31:0]      WriteData1,
  input  logic [4:0]       LookupReg,
  output logic             LookupHit,
  output logic [31:0]      LookupData,
  output logic [PTR_W:0]   Count,
  output logic             DropZero
);

  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] DEPTH_C = CW'(DEPTH);

  logic [4:0]       r_reg  [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_write;
  logic [4:0]       r_wreg;
  logic [31:0]      r_wdata;
  logic             r_drop;

  logic [PTR_W:0]   w_free;
  logic             w_mem_needs;
  logic             w_mem_acc;
  logic             w_alu_acc;
  logic             w_mem_push;
  logic             w_alu_push;
  logic             w_pop;
  logic [PTR_W-1:0] w_alu_slot;

  // Readiness uses occupancy at cycle start only; a same-cycle pop earns no credit.
  assign w_free      = DEPTH_C - r_count;
  assign w_mem_needs = MemValid && (MemReg != 5'd0);
  assign MemReady    = (w_free != '0);
  assign AluReady    = (w_free > CW'(w_mem_needs));

  assign w_mem_acc  = MemValid && MemReady;
  assign w_alu_acc  = AluValid && AluReady;
  assign w_mem_push = w_mem_acc && (MemReg != 5'd0);
  assign w_alu_push = w_alu_acc && (AluReg != 5'd0);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_wr_ptr + PTR_W'(w_mem_push);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_write  <= 1'b0;
      r_wreg   <= 5'd0;
      r_wdata  <= 32'd0;
      r_drop   <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_mem_push) + PTR_W'(w_alu_push);
      r_count  <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);
      r_drop   <= (w_mem_acc && (MemReg == 5'd0)) || (w_alu_acc && (AluReg == 5'd0));
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_write  <= 1'b1;
        r_wreg   <= r_reg[r_rd_ptr];
        r_wdata  <= r_data[r_rd_ptr];
      end else begin
        r_write  <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (w_mem_push) begin
      r_reg[r_wr_ptr]  <= MemReg;
      r_data[r_wr_ptr] <= MemData;
    end
    if (w_alu_push) begin
      r_reg[w_alu_slot]  <= AluReg;
      r_data[w_alu_slot] <= AluData;
    end
  end

  // Scan oldest to youngest so later matches override earlier ones.
  always_comb begin
    LookupHit  = 1'b0;
    LookupData = 32'd0;
    if (LookupReg != 5'd0) begin
      if (r_write && (r_wreg == LookupReg)) begin
        LookupHit  = 1'b1;
        LookupData = r_wdata;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < r_count) && (r_reg[r_rd_ptr + PTR_W'(i)] == LookupReg)) begin
          LookupHit  = 1'b1;
          LookupData = r_data[r_rd_ptr + PTR_W'(i)];
        end
      end
    end
  end

  assign Write1     = r_write;
  assign WriteReg1  = r_wreg;
  assign WriteData1 = r_wdata;
  assign Count      = r_count;
  assign DropZero   = r_drop;

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - self-checking bench for writeback_queue
// Queue-based reference model compared every cycle, plus hand-computed literal expectations.
module tb_writeback_queue;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MemValid, AluValid;
  logic [4:0]  MemReg, AluReg, LookupReg;
  logic [31:0] MemData, AluData;
  logic        MemReady, AluReady, Write1, LookupHit, DropZero;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1, LookupData;
  logic [2:0]  Count;

  writeback_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
    .Write1(Write1), .WriteReg1(WriteReg1), .WriteData1(WriteData1),
    .LookupReg(LookupReg), .LookupHit(LookupHit), .LookupData(LookupData),
    .Count(Count), .DropZero(DropZero)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [36:0] m_q[$];
  logic        m_w1;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  logic        m_drop;
  logic [36:0] dut_log[$];
  logic        saw_throttle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_w1 = 1'b0;
    m_wreg = 5'd0;
    m_wdata = 32'd0;
    m_drop = 1'b0;
  endtask

  function automatic logic model_mem_ready();
    return m_q.size() < 4;
  endfunction

  function automatic logic model_alu_ready(input logic mv, input logic [4:0] mr);
    int need;
    need = (mv && mr != 5'd0) ? 2 : 1;
    return (4 - m_q.size()) >= need;
  endfunction

  task automatic model_lookup(input logic [4:0] r, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d = 32'd0;
    if (r != 5'd0) begin
      for (int i = m_q.size() - 1; i >= 0; i--) begin
        if (m_q[i][36:32] == r) begin
          hit = 1'b1;
          d = m_q[i][31:0];
          break;
        end
      end
      if (!hit && m_w1 && m_wreg == r) begin
        hit = 1'b1;
        d = m_wdata;
      end
    end
  endtask

  task automatic check_comb();
    logic        h;
    logic [31:0] d;
    chk("MemReady", 32'(MemReady), 32'(model_mem_ready()));
    chk("AluReady", 32'(AluReady), 32'(model_alu_ready(MemValid, MemReg)));
    model_lookup(LookupReg, h, d);
    chk("LookupHit", 32'(LookupHit), 32'(h));
    chk("LookupData", LookupData, d);
  endtask

  task automatic check_regs();
    chk("Count", 32'(Count), 32'(m_q.size()));
    chk("Write1", 32'(Write1), 32'(m_w1));
    chk("WriteReg1", 32'(WriteReg1), 32'(m_wreg));
    chk("WriteData1", WriteData1, m_wdata);
    chk("DropZero", 32'(DropZero), 32'(m_drop));
    if (Write1) dut_log.push_back({WriteReg1, WriteData1});
  endtask

  task automatic model_edge(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                            input logic av, input logic [4:0] ar, input logic [31:0] ad,
                            output logic macc, output logic aacc);
    macc = mv && model_mem_ready();
    aacc = av && model_alu_ready(mv, mr);
    if (m_q.size() > 0) begin
      {m_wreg, m_wdata} = m_q.pop_front();
      m_w1 = 1'b1;
    end else begin
      m_w1 = 1'b0;
    end
    m_drop = (macc && mr == 5'd0) || (aacc && ar == 5'd0);
    if (macc && mr != 5'd0) m_q.push_back({mr, md});
    if (aacc && ar != 5'd0) m_q.push_back({ar, ad});
  endtask

  task automatic step(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic [4:0] lr, output logic macc, output logic aacc);
    @(negedge CLK);
    MemValid = mv; MemReg = mr; MemData = md;
    AluValid = av; AluReg = ar; AluData = ad;
    LookupReg = lr;
    #1;
    check_comb();
    if (av && !model_alu_ready(mv, mr)) saw_throttle = 1'b1;
    @(posedge CLK);
    model_edge(mv, mr, md, av, ar, ad, macc, aacc);
    #1;
    check_regs();
  endtask

  task automatic idle(input int n, input logic [4:0] lr);
    logic a, b;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, lr, a, b);
  endtask

  initial begin
    logic ma, aa;
    int mi, ai, cyc, hits;

    RESET = 1'b0;
    MemValid = 1'b0; MemReg = 5'd0; MemData = 32'd0;
    AluValid = 1'b0; AluReg = 5'd0; AluData = 32'd0;
    LookupReg = 5'd0;
    saw_throttle = 1'b0;
    model_reset();

    // Reset state and release
    @(posedge CLK); @(posedge CLK); #1;
    chk("rst_Write1", 32'(Write1), 32'd0);
    chk("rst_Count", 32'(Count), 32'd0);
    chk("rst_DropZero", 32'(DropZero), 32'd0);
    RESET = 1'b1;
    #1;
    chk("rel_MemReady", 32'(MemReady), 32'd1);
    chk("rel_AluReady", 32'(AluReady), 32'd1);

    // Single ALU write latency
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, ma, aa);
    chk("t2_count_n", 32'(Count), 32'd1);
    chk("t2_write_n", 32'(Write1), 32'd0);
    idle(1, 5'd5);
    chk("t2_write_n1", 32'(Write1), 32'd1);
    chk("t2_reg_n1", 32'(WriteReg1), 32'd5);
    chk("t2_data_n1", WriteData1, 32'hDEADBEEF);
    chk("t2_count_n1", 32'(Count), 32'd0);
    idle(1, 5'd5);
    chk("t2_write_n2", 32'(Write1), 32'd0);

    // Same register from both producers in one edge
    dut_log.delete();
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd0, ma, aa);
    chk("t3_count", 32'(Count), 32'd2);
    LookupReg = 5'd3;
    #1;
    chk("t3_hit", 32'(LookupHit), 32'd1);
    chk("t3_data", LookupData, 32'h22);
    idle(3, 5'd3);
    chk("t3_nwrites", 32'(dut_log.size()), 32'd2);
    if (dut_log.size() >= 2) begin
      chk("t3_first", 32'(dut_log[0]), 32'({5'd3, 32'h11}));
      chk("t3_second", 32'(dut_log[1]), 32'({5'd3, 32'h22}));
    end

    // Both producers streaming, each holding its request until accepted
    dut_log.delete();
    saw_throttle = 1'b0;
    mi = 0; ai = 0; cyc = 0;
    while ((mi < 6 || ai < 6) && cyc < 40) begin
      step(mi < 6, 5'(2 * mi + 1), 32'h100 * (2 * mi + 1),
           ai < 6, 5'(2 * ai + 2), 32'h100 * (2 * ai + 2),
           5'(cyc % 13), ma, aa);
      if (ma) mi++;
      if (aa) ai++;
      cyc++;
    end
    chk("t4_within_budget", 32'(cyc < 40), 32'd1);
    idle(6, 5'd0);
    chk("t4_throttled", 32'(saw_throttle), 32'd1);
    chk("t4_nwrites", 32'(dut_log.size()), 32'd12);
    for (int r = 1; r <= 12; r++) begin
      hits = 0;
      foreach (dut_log[k])
        if (dut_log[k][36:32] == 5'(r) && dut_log[k][31:0] == 32'h100 * r) hits++;
      chk($sformatf("t4_once_r%0d", r), 32'(hits), 32'd1);
    end

    // r0 request is dropped
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55, 5'd0, ma, aa);
    chk("t5_accepted", 32'(aa), 32'd1);
    chk("t5_drop", 32'(DropZero), 32'd1);
    chk("t5_count", 32'(Count), 32'd0);
    LookupReg = 5'd0;
    #1;
    chk("t5_lk_hit", 32'(LookupHit), 32'd0);
    chk("t5_lk_data", LookupData, 32'd0);
    idle(1, 5'd0);
    chk("t5_drop_clear", 32'(DropZero), 32'd0);
    chk("t5_no_write", 32'(Write1), 32'd0);

    // Asynchronous reset mid-drain
    step(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 5'd0, ma, aa);
    step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd0, ma, aa);
    chk("t6_count3", 32'(Count), 32'd3);
    #2;
    RESET = 1'b0;
    #1;
    chk("t6_async_write", 32'(Write1), 32'd0);
    chk("t6_async_count", 32'(Count), 32'd0);
    model_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    dut_log.delete();
    idle(4, 5'd9);
    chk("t6_no_stale", 32'(dut_log.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
